// File: rtl/sram_bridge.sv
// Byte-wide asynchronous SRAM bridge: one timed access per request within a
// start/finish transaction, with the address auto-incrementing after each access.
module sram_bridge #(
  parameter int ADDR_W    = 19,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [23:0]       start_addr,
  input  logic              is_write,
  input  logic [7:0]        wr_data,
  input  logic              wr_strobe,
  input  logic              rd_req,
  input  logic              finish,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {S_IDLE, S_READY, S_SETUP, S_PULSE, S_HOLD} state_t;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_is_write;
  logic                r_fin_pend;
  logic                r_err;
  logic                r_busy;
  logic [7:0]          r_rd_data;
  logic                r_rd_valid;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_we_n;
  logic [7:0]          r_dq_out;
  logic                r_dq_oe;

  logic w_req;
  logic w_bad_type;
  logic w_in_access;
  logic w_unused;

  // A request of the wrong kind for the open transaction is dropped and flagged.
  assign w_req       = r_is_write ? wr_strobe : rd_req;
  assign w_bad_type  = r_is_write ? rd_req    : wr_strobe;
  assign w_in_access = (r_state == S_SETUP) || (r_state == S_PULSE) || (r_state == S_HOLD);
  assign w_unused    = ^start_addr[23:ADDR_W];

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; later assignments in this block deliberately override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_is_write <= 1'b0;
      r_fin_pend <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_dq_out   <= 8'h00;
      r_dq_oe    <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_in_access) begin
        if (rd_req || wr_strobe) r_err <= 1'b1;
        if (finish)              r_fin_pend <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr     <= start_addr[ADDR_W-1:0];
            r_is_write <= is_write;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_fin_pend <= 1'b0;
            r_state    <= S_READY;
          end
        end
        S_READY: begin
          if (w_bad_type) r_err <= 1'b1;
          if (w_req) begin
            r_ce_n     <= 1'b0;
            r_oe_n     <= r_is_write;
            r_dq_oe    <= r_is_write;
            if (r_is_write) r_dq_out <= wr_data;
            r_cnt      <= SETUP_LD;
            r_fin_pend <= finish;
            r_state    <= S_SETUP;
          end else if (finish) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SETUP: begin
          if (r_cnt == 4'd0) begin
            r_we_n  <= ~r_is_write;
            r_cnt   <= PULSE_LD;
            r_state <= S_PULSE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_PULSE: begin
          if (r_cnt == 4'd0) begin
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            if (!r_is_write) r_rd_data <= sram_dq_in;
            r_cnt   <= HOLD_LD;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == 4'd0) begin
            r_ce_n     <= 1'b1;
            r_dq_oe    <= 1'b0;
            r_addr     <= r_addr + 1'b1;
            r_rd_valid <= ~r_is_write;
            r_fin_pend <= 1'b0;
            // A finish seen at any point during the access closes it here.
            if (r_fin_pend || finish) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_READY;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign busy        = r_busy;
  assign err         = r_err;
  assign sram_addr   = r_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge with a small behavioural SRAM model.
module tb_sram_bridge;

  logic        clk = 1'b0;
  logic        rst, start, is_write, wr_strobe, rd_req, finish;
  logic [23:0] start_addr;
  logic [7:0]  wr_data, rd_data, sram_dq_out, sram_dq_in;
  logic        rd_valid, busy, err, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [18:0] sram_addr;

  logic [7:0]  mem [0:1023];
  int          checks = 0;
  int          failures = 0;
  int          we_low = 0;
  int          oe_viol = 0;
  int          lat;
  int          rv_cnt;
  logic        in_read = 1'b0;

  sram_bridge dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .is_write(is_write), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .rd_req(rd_req), .finish(finish), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .err(err), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: combinational read while OE is low, write while CE and WE are low.
  assign sram_dq_in = sram_oe_n ? 8'hEE : mem[sram_addr[9:0]];

  always @(posedge clk) begin
    if (!rst && !sram_ce_n && !sram_we_n) mem[sram_addr[9:0]] = sram_dq_out;
    if (!sram_we_n) we_low++;
    if (in_read && sram_dq_oe) oe_viol++;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic open_txn(input logic [23:0] addr, input logic wr);
    start = 1'b1; start_addr = addr; is_write = wr;
    step();
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_rd [3];
    exp_rd = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33;

    rst = 1'b1; start = 1'b0; is_write = 1'b0; wr_strobe = 1'b0; rd_req = 1'b0;
    finish = 1'b0; start_addr = '0; wr_data = '0;
    step(2);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
    check("rst_rd", {rd_data, rd_valid, err}, 10'h000);
    check("rst_addr", sram_addr, 0);

    // Read burst of three bytes, requests six cycles apart.
    in_read = 1'b1;
    open_txn(24'h000100, 1'b0);
    check("rd_open", {busy, err}, 2'b10);
    check("rd_open_addr", sram_addr, 19'h100);
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      check($sformatf("rd%0d_setup_strobes", i), {sram_ce_n, sram_oe_n}, 2'b00);
      lat = 1;
      while (!rd_valid && lat < 20) begin
        step();
        lat++;
        if (i == 0 && lat == 4) check("rd_hold_strobes", {sram_ce_n, sram_oe_n}, 2'b01);
      end
      check($sformatf("rd%0d_latency", i), lat, 5);
      check($sformatf("rd%0d_data", i), rd_data, exp_rd[i]);
      step();
      check($sformatf("rd%0d_valid_oneshot", i), {rd_valid, rd_data}, {1'b0, exp_rd[i]});
    end
    check("rd_end_addr", sram_addr, 19'h103);
    finish = 1'b1;
    step();
    finish = 1'b0;
    check("rd_finish_idle", busy, 0);

    // Two writes across the address wrap; the second carries finish as well.
    in_read = 1'b0;
    we_low = 0;
    open_txn(24'h07FFFF, 1'b1);
    wr_strobe = 1'b1; wr_data = 8'hA5;
    step();
    wr_strobe = 1'b0;
    check("wr_setup", {sram_dq_oe, sram_dq_out, sram_we_n, sram_ce_n}, {1'b1, 8'hA5, 2'b10});
    step();
    check("wr_pulse_we", sram_we_n, 0);
    step(2);
    check("wr_hold", {sram_we_n, sram_dq_oe, sram_dq_out}, {2'b11, 8'hA5});
    step();
    check("wr_done", {sram_dq_oe, sram_ce_n}, 2'b01);
    check("wr_wrap_addr", sram_addr, 19'h0);
    wr_strobe = 1'b1; wr_data = 8'h5A; finish = 1'b1;
    step();
    wr_strobe = 1'b0; finish = 1'b0;
    step(4);
    check("wr_close_busy", busy, 0);
    check("wr_mem_top", mem[10'h3FF], 8'hA5);
    check("wr_mem_zero", mem[10'h000], 8'h5A);
    check("wr_we_cycles", we_low, 4);
    check("wr_err", err, 0);

    // Overrun: a second rd_req two cycles after the first.
    in_read = 1'b1;
    open_txn(24'h000100, 1'b0);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rd_valid) rv_cnt++;
    end
    check("ovr_one_access", rv_cnt, 1);
    check("ovr_addr", sram_addr, 19'h101);
    check("ovr_data", rd_data, 8'h11);
    check("ovr_err", err, 1);
    finish = 1'b1;
    step();
    finish = 1'b0;
    check("ovr_err_sticky", {busy, err}, 2'b01);
    open_txn(24'h000102, 1'b0);
    check("ovr_err_cleared", {busy, err}, 2'b10);

    // finish during the read PULSE.
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    finish = 1'b1;
    step();
    finish = 1'b0;
    step();
    check("fin_hold_busy", busy, 1);
    step();
    check("fin_rd_valid", {rd_valid, rd_data}, {1'b1, 8'h33});
    step();
    check("fin_idle", {busy, rd_valid}, 2'b00);

    // wr_strobe inside a read transaction.
    open_txn(24'h000100, 1'b0);
    wr_strobe = 1'b1; wr_data = 8'hC3;
    step();
    wr_strobe = 1'b0;
    check("mis_no_cycle", {sram_ce_n, sram_dq_oe, err}, 3'b101);
    step(5);
    check("mis_addr", {busy, sram_ce_n, sram_addr}, {2'b11, 19'h100});
    finish = 1'b1;
    step();
    finish = 1'b0;
    in_read = 1'b0;
    check("rd_dq_oe_never", oe_viol, 0);

    // Reset during a write PULSE, then a normal write.
    open_txn(24'h000200, 1'b1);
    wr_strobe = 1'b1; wr_data = 8'h77;
    step();
    wr_strobe = 1'b0;
    step();
    check("rstw_pulse", sram_we_n, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw_strobes", {sram_we_n, sram_dq_oe, sram_ce_n, busy}, 4'b1010);
    check("rstw_regs", {sram_addr, rd_data, err}, 28'h0);
    open_txn(24'h000300, 1'b1);
    wr_strobe = 1'b1; wr_data = 8'h99; finish = 1'b1;
    step();
    wr_strobe = 1'b0; finish = 1'b0;
    step(4);
    check("rstw_after_busy", busy, 0);
    check("rstw_after_mem", mem[10'h300], 8'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_bridge.md
SRAM_BRIDGE -- requirements
Module: sram_bridge

Interface
REQ-001 Parameter ADDR_W, 19, SRAM address width.
REQ-002 Parameter SETUP_CYC, 1, address/data setup cycles before the strobe (range 1..15).
REQ-003 Parameter PULSE_CYC, 2, strobe-active cycles (range 1..15).
REQ-004 Parameter HOLD_CYC, 1, cycles after strobe release before the next access (range 1..15).
REQ-005 Ports SHALL be as follows:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; opens a transaction.
- start_addr  in  24  first byte address; bits above ADDR_W-1 are ignored.
- is_write  in  1  sampled with start: 1 = write transaction, 0 = read transaction.
- wr_data  in  8  write byte; sampled with wr_strobe.
- wr_strobe  in  1  one-cycle pulse; a write byte is available.
- rd_req  in  1  one-cycle pulse; fetch the next read byte.
- finish  in  1  one-cycle pulse; closes the transaction.
- rd_data  out  8  last byte read; held until the next read completes.
- rd_valid  out  1  one-cycle pulse; rd_data has been updated.
- busy  out  1  high from start until return to IDLE.
- err  out  1  sticky request-overrun or request-type-mismatch flag.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dq_out  out  8  SRAM write data.
- sram_dq_oe  out  1  data bus output enable for the pad tristate.
- sram_dq_in  in  8  SRAM read data.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-006 States SHALL be IDLE, READY, SETUP, PULSE, HOLD; a single down-counter SHALL time SETUP, PULSE and HOLD.
REQ-007 IDLE: when start=1, the block SHALL latch start_addr[ADDR_W-1:0] into the address counter, latch is_write, clear err, set busy, and go to READY.
REQ-008 READY, read transaction: when rd_req=1, the block SHALL go to SETUP with sram_ce_n=0 and sram_oe_n=0.
REQ-009 READY, write transaction: when wr_strobe=1, the block SHALL latch wr_data into sram_dq_out, set sram_dq_oe=1, drive sram_ce_n=0, and go to SETUP.
REQ-010 The block SHALL stay SETUP_CYC cycles in SETUP, then PULSE_CYC cycles in PULSE, then HOLD_CYC cycles in HOLD, and then return to READY.
REQ-011 Write PULSE: sram_we_n SHALL be 0 only while in PULSE; sram_dq_out and sram_dq_oe SHALL stay stable through HOLD.
REQ-012 Read PULSE: rd_data SHALL capture sram_dq_in on the last PULSE cycle.
REQ-013 The strobe outputs SHALL be as follows:
- sram_oe_n SHALL deassert on entry to HOLD.
- sram_ce_n SHALL deassert on exit from HOLD.
- sram_dq_oe SHALL be 0 at all times during read transactions.
REQ-014 rd_valid SHALL pulse for exactly one cycle, on the first READY cycle after a read, so that the latency from rd_req to rd_valid is SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles (5 with defaults).
REQ-015 The address counter SHALL increment by 1 on exit from HOLD and wrap from 2^ADDR_W-1 to 0 with no flag; sram_addr SHALL equal the counter at all times.
REQ-016 Overrun: rd_req or wr_strobe while in SETUP, PULSE or HOLD SHALL be dropped and SHALL set err.
REQ-017 Type mismatch: rd_req in a write transaction, or wr_strobe in a read transaction, SHALL be dropped and SHALL set err.
REQ-018 finish handling SHALL be as follows:
- finish in READY SHALL return the block to IDLE on the next cycle.
- finish in SETUP, PULSE or HOLD SHALL be remembered, and the block SHALL go to IDLE instead of READY once the access completes, with rd_valid still pulsed for a read.
REQ-019 Simultaneous finish and request in READY SHALL perform the request first and then close.
REQ-020 start outside IDLE SHALL be ignored; start together with finish in IDLE SHALL open the transaction and ignore finish.
REQ-021 busy SHALL be 0 only in IDLE; err SHALL hold until the next accepted start or reset.

Reset
REQ-022 rst=1 in any state, including mid-access, SHALL on the next edge set:
- state=IDLE, counters=0, sram_addr=0
- sram_ce_n=sram_oe_n=sram_we_n=1, sram_dq_oe=0
- rd_data=0x00, rd_valid=0, busy=0, err=0, pending finish cleared.

Verification
REQ-023 Read burst: start addr=0x000100 with is_write=0, rd_req x3 spaced 6 cycles, SRAM model holding 0x11,0x22,0x33 -> rd_valid 5 cycles after each rd_req with rd_data 0x11,0x22,0x33, and sram_addr ends at 0x103.
REQ-024 Write: start addr=0x7FFFF with is_write=1, wr_strobe with 0xA5 then 0x5A -> sram_we_n low for 2 cycles per byte, 0xA5 at 0x7FFFF, 0x5A at 0x00000 (wrap), err=0.
REQ-025 Overrun: rd_req, then a second rd_req 2 cycles later -> one access only, err=1, and err cleared by the next start.
REQ-026 finish asserted during the PULSE of a read -> rd_valid still pulses, then the block is in IDLE with busy=0 on the cycle after.
REQ-027 rst asserted during a write PULSE -> next cycle sram_we_n=1, sram_dq_oe=0, busy=0; a subsequent start operates normally.
REQ-028 wr_strobe during a read transaction -> no SRAM cycle, sram_dq_oe stays 0, err=1.
